// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: default widths, FSM state codes and port ids.
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 14;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_CNT_W  = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester always wins, a tie goes to ptr_i.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_c,
    output logic       sel_c
);

    always_comb begin
        sel_c = ptr_i;
        gnt_c = 2'b00;
        case (req_i)
            2'b01:   sel_c = 1'b0;
            2'b10:   sel_c = 1'b1;
            default: sel_c = ptr_i;
        endcase
        if (req_i != 2'b00) begin
            gnt_c = sel_c ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory; every access is IDLE -> ACCESS -> RESP.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
`ifdef DMEM_ARB_PERF_EN
    ,
    parameter int unsigned CNT_W  = DMEM_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0_o,
    output logic [CNT_W-1:0]  gnt_cnt1_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
`endif
);

    logic [1:0]        state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_sel_q, we_sel_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]        arb_gnt;
    logic              arb_sel;

    rr_arb2 u_rr_arb2 (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_c (arb_gnt),
        .sel_c (arb_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= PORT_CPU;
            we_sel_q    <= 1'b0;
            rr_ptr_q    <= 1'b0;
            ack_q       <= 2'b00;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            we_sel_q    <= we_sel_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // The memory address/data flops double as the selected-request registers.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        we_sel_d    = we_sel_q;
        rr_ptr_d    = rr_ptr_q;
        ack_d       = 2'b00;
        rdata_d     = rdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    sel_d       = arb_sel;
                    we_sel_d    = |(arb_gnt & we_i);
                    mem_addr_d  = (arb_sel == PORT_LDR) ? addr1_i  : addr0_i;
                    mem_wdata_d = (arb_sel == PORT_LDR) ? wdata1_i : wdata0_i;
                    mem_write_d = |(arb_gnt & we_i);
                    mem_read_d  = ~(|(arb_gnt & we_i));
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_sel_q) begin
                    rdata_d = mem_rdata_i;
                end
                ack_d   = (sel_q == PORT_CPU) ? 2'b01 : 2'b10;
                state_d = S_RESP;
            end
            S_RESP: begin
                rr_ptr_d = ~sel_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            gnt_cnt0_q     <= gnt_cnt0_d;
            gnt_cnt1_q     <= gnt_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Saturating counters: grants counted in RESP, contention counted per IDLE cycle.
    always_comb begin
        gnt_cnt0_d     = gnt_cnt0_q;
        gnt_cnt1_d     = gnt_cnt1_q;
        conflict_cnt_d = conflict_cnt_q;
        if (state_q == S_RESP) begin
            if (sel_q == PORT_CPU && !(&gnt_cnt0_q)) begin
                gnt_cnt0_d = gnt_cnt0_q + CNT_W'(1);
            end
            if (sel_q == PORT_LDR && !(&gnt_cnt1_q)) begin
                gnt_cnt1_d = gnt_cnt1_q + CNT_W'(1);
            end
        end
        if (state_q == S_IDLE && req_i == 2'b11 && !(&conflict_cnt_q)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    assign gnt_cnt0_o     = gnt_cnt0_q;
    assign gnt_cnt1_o     = gnt_cnt1_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
